// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_if
// Brief    : Requester-side bus of the shared-register write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int c_PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       ack;
    logic               reg_load;
    logic [WIDTH-1:0]   reg_d;
    logic               busy;
    logic [c_PW-1:0]    owner;

    // master = requester/CPU side, slave = the arbiter itself
    modport master (
        output req, wdata,
        input  ack, reg_load, reg_d, busy, owner
    );

    modport slave (
        input  req, wdata,
        output ack, reg_load, reg_d, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin write sequencer for one shared DFF-built register.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    reg_write_arbiter_if.slave bus
);
    localparam int c_PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_PW-1:0]  r_ptr;
    logic [c_PW-1:0]  r_owner;
    logic [WIDTH-1:0] r_reg_d;

    logic             w_grant_valid;
    logic [c_PW-1:0]  w_grant_idx;
    logic [c_PW-1:0]  w_ptr_nxt;
    logic [N-1:0]     w_ack;

    // Scan from the highest offset down so the smallest offset from r_ptr wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[(int'(r_ptr) + k) % N]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = c_PW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_ptr_nxt = (r_owner == c_PW'(N - 1)) ? '0 : r_owner + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE: w_state_nxt = w_grant_valid ? c_ST_LOAD : c_ST_IDLE;
            c_ST_LOAD: w_state_nxt = c_ST_ACK;
            c_ST_ACK:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Grant capture and pointer advance; the write is frozen once sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_reg_d <= '0;
        end else begin
            if (r_state == c_ST_IDLE && w_grant_valid) begin
                r_owner <= w_grant_idx;
                r_reg_d <= bus.wdata[w_grant_idx*WIDTH +: WIDTH];
            end
            if (r_state == c_ST_ACK) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        w_ack = '0;
        if (r_state == c_ST_ACK) begin
            w_ack[r_owner] = 1'b1;
        end
    end

    assign bus.ack      = w_ack;
    assign bus.reg_load = (r_state == c_ST_LOAD);
    assign bus.busy     = (r_state != c_ST_IDLE);
    assign bus.reg_d    = r_reg_d;
    assign bus.owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Self-checking bench for reg_write_arbiter (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   mdl_ptr = 0;
    int   waits [N];
    int   w_last;

    reg_write_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    reg_write_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first set request scanning upward from the pointer.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ack"},   bus.ack, 0);
        chk({tag, "_load"},  bus.reg_load, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_owner"}, bus.owner, 0);
        chk({tag, "_regd"},  bus.reg_d, 0);
    endtask

    // One full write transaction starting in IDLE with bus.req already set.
    task automatic do_write(input bit mutate, output int w);
        logic [W-1:0] d;
        w = pick(bus.req, mdl_ptr);
        d = bus.wdata[w*W +: W];
        tick();
        chk("load_strobe", bus.reg_load, 1);
        chk("load_data",   bus.reg_d, d);
        chk("load_owner",  bus.owner, w);
        chk("load_busy",   bus.busy, 1);
        chk("load_ack",    bus.ack, 0);
        if (mutate) begin
            bus.wdata[w*W +: W] = {W{1'b1}};
            bus.req[w] = 1'b0;
        end
        tick();
        chk("ack_pulse", bus.ack, 64'(1) << w);
        chk("ack_load",  bus.reg_load, 0);
        chk("ack_busy",  bus.busy, 1);
        chk("ack_data",  bus.reg_d, d);
        bus.req[w] = 1'b0;
        tick();
        chk("idle_busy",  bus.busy, 0);
        chk("idle_ack",   bus.ack, 0);
        chk("idle_owner", bus.owner, w);
        chk("idle_data",  bus.reg_d, d);
        mdl_ptr = (w + 1) % N;
    endtask

    initial begin
        bus.req   = N'($urandom);
        bus.wdata = {$urandom, $urandom};

        // Reset with random traffic on the inputs
        rst = 1'b1;
        tick();
        check_idle_zero("rst1");
        bus.req = N'($urandom);
        tick();
        check_idle_zero("rst2");
        rst = 1'b0;
        mdl_ptr = 0;
        bus.req = N'($urandom_range(1, (1 << N) - 1));
        do_write(1'b0, w_last);
        bus.req = '0;
        tick();

        // Full contention held through reset
        rst = 1'b1;
        bus.req = '1;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        check_idle_zero("rst3");
        rst = 1'b0;
        mdl_ptr = 0;
        for (int i = 0; i < N; i++) begin
            do_write(1'b0, w_last);
            chk("contention_order", w_last, i);
        end

        // Single write, then round-robin wrap
        bus.wdata[2*W +: W] = 8'hA5;
        bus.req = 4'b0100;
        do_write(1'b0, w_last);
        bus.req = 4'b0101;
        do_write(1'b0, w_last);
        chk("wrap_first", w_last, 0);
        do_write(1'b0, w_last);
        chk("wrap_second", w_last, 2);

        // Data and request change after sampling
        bus.wdata[1*W +: W] = 8'h3C;
        bus.req = 4'b0010;
        do_write(1'b1, w_last);

        // Reset during LOAD aborts the write
        bus.req = 4'b0100;
        tick();
        chk("abort_load", bus.reg_load, 1);
        rst = 1'b1;
        tick();
        check_idle_zero("abort");
        rst = 1'b0;
        bus.req = '0;
        mdl_ptr = 0;
        tick();
        chk("abort_quiet_ack",  bus.ack, 0);
        chk("abort_quiet_busy", bus.busy, 0);
        bus.req = 4'b1001;
        do_write(1'b0, w_last);
        chk("post_abort_ptr", w_last, 0);
        do_write(1'b0, w_last);
        chk("post_abort_req3", w_last, 3);

        // Random traffic with a bounded-wait fairness check
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && ($urandom_range(0, 1) == 1)) begin
                    bus.req[i] = 1'b1;
                    bus.wdata[i*W +: W] = W'($urandom);
                    waits[i] = 0;
                end
            end
            if (bus.req == '0) begin
                tick();
                chk("rand_idle_busy", bus.busy, 0);
            end else begin
                logic [N-1:0] pend;
                pend = bus.req;
                do_write(1'b0, w_last);
                chk("rand_wait_bound", (waits[w_last] <= N - 1), 1);
                for (int i = 0; i < N; i++)
                    if (pend[i] && i != w_last) waits[i]++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
